// File: rtl/mod_dm_pipe_pkg.sv
// Shared types and constant helpers for the pipelined data memory.
package dm_pkg;

    typedef enum logic {
        INIT,
        RUN
    } dm_state_t;

    function automatic int unsigned dm_bytes(input int unsigned data_w);
        return data_w / 8;
    endfunction

    function automatic int unsigned dm_idx_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mod_dm_pipe_if.sv
// Request/response bus between the MEM stage and the data memory.
interface mod_dm_pipe_if
    import dm_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) ();

    logic                          req_valid;
    logic                          req_ready;
    logic                          req_write;
    logic [31:0]                   address;
    logic [DATA_W-1:0]             dm_data_in;
    logic [dm_bytes(DATA_W)-1:0]   BE;
    logic [31:0]                   pc_now;
    logic                          rsp_valid;
    logic [DATA_W-1:0]             dm_data_out;
    logic                          rsp_err;

    modport master (
        output req_valid, req_write, address, dm_data_in, BE, pc_now,
        input  req_ready, rsp_valid, dm_data_out, rsp_err
    );

    modport slave (
        input  req_valid, req_write, address, dm_data_in, BE, pc_now,
        output req_ready, rsp_valid, dm_data_out, rsp_err
    );

endinterface

// File: rtl/mod_dm_pipe_rsp_pipe.sv
// In-order response shift register with asynchronous active-low clear.
module dm_rsp_pipe #(
    parameter type         stage_t = logic,
    parameter int unsigned LAT     = 1
) (
    input  logic   clk,
    input  logic   rst_n,
    input  stage_t d,
    output stage_t q
);

    stage_t pipe [LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= d;
            for (int unsigned i = 1; i < LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign q = pipe[LAT-1];

endmodule

// File: rtl/mod_dm_pipe.sv
// Pipelined byte-enabled data memory with self-clear after reset.
// Define DM_WRITE_LOG_EN to print one line per effective write in simulation.
module mod_dm_pipe
    import dm_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned RD_LAT      = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input logic          clk,
    input logic          reset,
    mod_dm_pipe_if.slave bus
);

    localparam int unsigned BYTES = dm_bytes(DATA_W);
    localparam int unsigned IDX_W = dm_idx_w(DEPTH_WORDS);
    localparam int unsigned OFS_W = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) * 33'(BYTES);

    typedef struct packed {
        logic              valid;
        logic              err;
        logic [DATA_W-1:0] data;
    } rsp_stage_t;

    dm_state_t         state, state_nx;
    logic [IDX_W-1:0]  init_cnt, init_cnt_nx;
    logic              ready;
    logic              accept;
    logic              in_range;
    logic [31:0]       offset;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] mem [DEPTH_WORDS];
    rsp_stage_t        cap, rsp_out;

    assign offset   = bus.address - BASE_ADDR;
    assign in_range = (bus.address >= BASE_ADDR) && ({1'b0, offset} < SPAN);
    assign idx      = offset[OFS_W +: IDX_W];
    assign accept   = bus.req_valid && ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nx;
            init_cnt <= init_cnt_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        init_cnt_nx = init_cnt;
        ready       = 1'b0;
        case (state)
            INIT: begin
                init_cnt_nx = init_cnt + 1'b1;
                if (init_cnt == IDX_W'(DEPTH_WORDS - 1)) begin
                    state_nx = RUN;
                end
            end
            RUN:     ready    = 1'b1;
            default: state_nx = INIT;
        endcase
    end

    always_comb begin
        merged = mem[idx];
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (bus.BE[i]) begin
                merged[8*i +: 8] = bus.dm_data_in[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[init_cnt] <= '0;
        end else if (accept && bus.req_write && in_range) begin
            mem[idx] <= merged;
        end
    end

    // Capture register samples the array at the accepting edge; the
    // RD_LAT-deep pipe behind it delivers the response at edge n+RD_LAT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap <= '0;
        end else begin
            cap.valid <= accept;
            cap.err   <= accept && !in_range;
            cap.data  <= (accept && !bus.req_write && in_range) ? mem[idx] : '0;
        end
    end

    dm_rsp_pipe #(
        .stage_t (rsp_stage_t),
        .LAT     (RD_LAT)
    ) u_rsp_pipe (
        .clk   (clk),
        .rst_n (reset),
        .d     (cap),
        .q     (rsp_out)
    );

    assign bus.req_ready   = ready;
    assign bus.rsp_valid   = rsp_out.valid;
    assign bus.rsp_err     = rsp_out.err;
    assign bus.dm_data_out = rsp_out.data;

`ifdef DM_WRITE_LOG_EN
    logic [31:0] word_addr;
    assign word_addr = bus.address & ~32'(BYTES - 1);

    always_ff @(posedge clk) begin
        if (accept && bus.req_write && in_range && (|bus.BE)) begin
            $display("@%08h: *%08h <= %08h", bus.pc_now, word_addr, merged);
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^bus.pc_now;
`endif

endmodule
